// File: rtl/elite_select.sv
// elite_select: captures a sorted fitness set on the sorter's sortdone strobe
// and streams the top K entries, best first, over a valid/ready interface.
// A sortdone that arrives mid-stream (other than on the final handshake) is
// dropped and reported on overrun.
module elite_select #(
  parameter int INPUTVALS      = 16,
  parameter int INPUTBITWIDTHS = 32,
  parameter int BEST_HIGH      = 1,
  localparam int P             = $clog2(INPUTVALS) + 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                sortdone,
  input  logic [INPUTVALS*INPUTBITWIDTHS-1:0] sorted,
  input  logic [INPUTVALS*P-1:0]              sorted_positions,
  input  logic [P-1:0]                        elite_count,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [INPUTBITWIDTHS-1:0]           out_value,
  output logic [P-1:0]                        out_index,
  output logic [P-1:0]                        out_rank,
  output logic                                out_last,
  output logic                                busy,
  output logic                                done,
  output logic                                overrun
);

  localparam int unsigned N  = INPUTVALS;
  localparam int unsigned W  = INPUTBITWIDTHS;
  localparam int unsigned SW = $clog2(INPUTVALS);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    STREAM = 2'b01
  } state_t;

  state_t state_q, state_n;

  logic [W-1:0] val_q [N];
  logic [P-1:0] pos_q [N];
  logic [P-1:0] rank_q;
  logic [P-1:0] k_q;
  logic         done_q;
  logic         overrun_q;

  logic         stream;
  logic         hs;
  logic         last_hs;
  logic         accept;
  logic         overrun_n;
  logic         rank_is_last;
  logic [P-1:0] k_in;
  logic [SW-1:0] slot;

  // K clamp: zero or anything above N means the whole set
  always_comb begin
    k_in = elite_count;
    if (elite_count == '0 || elite_count > P'(N)) begin
      k_in = P'(N);
    end
  end

  // Map rank to a slot of the captured arrays according to the best end
  always_comb begin
    slot = rank_q[SW-1:0];
    if (BEST_HIGH != 0) begin
      slot = SW'(N - 1) - rank_q[SW-1:0];
    end
  end

  assign rank_is_last = (rank_q == k_q - P'(1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Next state, handshake detection and capture acceptance
  always_comb begin
    state_n   = state_q;
    stream    = 1'b0;
    hs        = 1'b0;
    last_hs   = 1'b0;
    accept    = 1'b0;
    overrun_n = 1'b0;
    case (state_q)
      IDLE: begin
        if (sortdone) begin
          accept  = 1'b1;
          state_n = STREAM;
        end
      end
      STREAM: begin
        stream = 1'b1;
        if (out_ready) begin
          hs = 1'b1;
          if (rank_is_last) begin
            last_hs = 1'b1;
            // a strobe coinciding with the final handshake starts the next stream directly
            accept  = sortdone;
            state_n = sortdone ? STREAM : IDLE;
          end
        end
        if (sortdone && !last_hs) begin
          overrun_n = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Capture registers, rank counter and status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < N; i++) begin
        val_q[i] <= '0;
        pos_q[i] <= '0;
      end
      rank_q    <= '0;
      k_q       <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      done_q    <= last_hs;
      overrun_q <= overrun_n;
      if (accept) begin
        for (int unsigned i = 0; i < N; i++) begin
          val_q[i] <= sorted[i*W +: W];
          pos_q[i] <= sorted_positions[i*P +: P];
        end
        k_q    <= k_in;
        rank_q <= '0;
      end else if (hs) begin
        rank_q <= rank_q + P'(1);
      end
    end
  end

  // Outputs are a mux of registered state, forced to zero outside STREAM
  always_comb begin
    out_valid = stream;
    busy      = stream;
    out_value = stream ? val_q[slot] : '0;
    out_index = stream ? pos_q[slot] : '0;
    out_rank  = stream ? rank_q : '0;
    out_last  = stream && rank_is_last;
    done      = done_q;
    overrun   = overrun_q;
  end

endmodule

// File: tb/tb_elite_select.sv
// Bench for elite_select: two instances (best-high and best-low) share the
// stimulus; expected entries are queued per instance and a monitor pops and
// compares on every handshake.
module tb_elite_select;

  localparam int N = 4;
  localparam int W = 8;
  localparam int P = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           sortdone;
  logic [N*W-1:0] sorted;
  logic [N*P-1:0] sorted_positions;
  logic [P-1:0]   elite_count;
  logic           out_ready;

  logic           hi_valid, hi_last, hi_busy, hi_done, hi_overrun;
  logic [W-1:0]   hi_value;
  logic [P-1:0]   hi_index, hi_rank;
  logic           lo_valid, lo_last, lo_busy, lo_done, lo_overrun;
  logic [W-1:0]   lo_value;
  logic [P-1:0]   lo_index, lo_rank;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] v;
    logic [P-1:0] i;
    logic [P-1:0] r;
    logic         l;
  } exp_t;

  exp_t q_hi[$];
  exp_t q_lo[$];

  localparam logic [N*W-1:0] D1 = {8'd20, 8'd9, 8'd7, 8'd3};
  localparam logic [N*P-1:0] P1 = {3'd1, 3'd3, 3'd0, 3'd2};
  localparam logic [N*W-1:0] D2 = {8'd50, 8'd40, 8'd30, 8'd10};
  localparam logic [N*P-1:0] P2 = {3'd0, 3'd1, 3'd2, 3'd3};

  always #5 clk = ~clk;

  elite_select #(.INPUTVALS(N), .INPUTBITWIDTHS(W), .BEST_HIGH(1)) dut_hi (
    .clk(clk), .reset(reset), .sortdone(sortdone), .sorted(sorted),
    .sorted_positions(sorted_positions), .elite_count(elite_count),
    .out_valid(hi_valid), .out_ready(out_ready), .out_value(hi_value),
    .out_index(hi_index), .out_rank(hi_rank), .out_last(hi_last),
    .busy(hi_busy), .done(hi_done), .overrun(hi_overrun)
  );

  elite_select #(.INPUTVALS(N), .INPUTBITWIDTHS(W), .BEST_HIGH(0)) dut_lo (
    .clk(clk), .reset(reset), .sortdone(sortdone), .sorted(sorted),
    .sorted_positions(sorted_positions), .elite_count(elite_count),
    .out_valid(lo_valid), .out_ready(out_ready), .out_value(lo_value),
    .out_index(lo_index), .out_rank(lo_rank), .out_last(lo_last),
    .busy(lo_busy), .done(lo_done), .overrun(lo_overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the first n entries of a stream of length k for both orderings
  task automatic push_exp(input logic [N*W-1:0] d, input logic [N*P-1:0] p,
                          input int k, input int n);
    for (int r = 0; r < n; r++) begin
      exp_t eh;
      exp_t el;
      int sh;
      sh   = N - 1 - r;
      eh.v = d[sh*W +: W];
      eh.i = p[sh*P +: P];
      eh.r = P'(r);
      eh.l = (r == k - 1);
      el.v = d[r*W +: W];
      el.i = p[r*P +: P];
      el.r = P'(r);
      el.l = (r == k - 1);
      q_hi.push_back(eh);
      q_lo.push_back(el);
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (hi_busy && n < 40) begin
      tick();
      n++;
    end
    chk("idle_timeout_hi", 32'(hi_busy), 32'd0);
    chk("idle_lo", 32'(lo_busy), 32'd0);
  endtask

  // Scoreboard monitor, best-high instance
  always @(negedge clk) begin
    exp_t e;
    if (!reset && hi_valid && out_ready) begin
      if (q_hi.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL hi_unexpected actual=%0d required=none", hi_value);
      end else begin
        e = q_hi.pop_front();
        chk("hi_value", 32'(hi_value), 32'(e.v));
        chk("hi_index", 32'(hi_index), 32'(e.i));
        chk("hi_rank",  32'(hi_rank),  32'(e.r));
        chk("hi_last",  32'(hi_last),  32'(e.l));
      end
    end
  end

  // Scoreboard monitor, best-low instance
  always @(negedge clk) begin
    exp_t e;
    if (!reset && lo_valid && out_ready) begin
      if (q_lo.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL lo_unexpected actual=%0d required=none", lo_value);
      end else begin
        e = q_lo.pop_front();
        chk("lo_value", 32'(lo_value), 32'(e.v));
        chk("lo_index", 32'(lo_index), 32'(e.i));
        chk("lo_rank",  32'(lo_rank),  32'(e.r));
        chk("lo_last",  32'(lo_last),  32'(e.l));
      end
    end
  end

  initial begin
    int n;
    reset            = 1'b1;
    sortdone         = 1'b0;
    sorted           = '0;
    sorted_positions = '0;
    elite_count      = '0;
    out_ready        = 1'b0;
    tick();
    tick();
    chk("rst_valid",   32'(hi_valid),   32'd0);
    chk("rst_busy",    32'(hi_busy),    32'd0);
    chk("rst_done",    32'(hi_done),    32'd0);
    chk("rst_overrun", 32'(hi_overrun), 32'd0);
    chk("rst_value",   32'(hi_value),   32'd0);
    chk("rst_rank",    32'(hi_rank),    32'd0);
    reset = 1'b0;
    tick();

    // Basic run, K=2, ready held high
    sorted = D1; sorted_positions = P1; elite_count = 3'd2; out_ready = 1'b1;
    push_exp(D1, P1, 2, 2);
    sortdone = 1'b1;
    tick();
    sortdone = 1'b0;
    chk("b_busy0",  32'(hi_busy),  32'd1);
    chk("b_rank0",  32'(hi_rank),  32'd0);
    chk("b_value0", 32'(hi_value), 32'd20);
    tick();
    chk("b_busy1",  32'(hi_busy),  32'd1);
    chk("b_last1",  32'(hi_last),  32'd1);
    tick();
    chk("b_done",   32'(hi_done),  32'd1);
    chk("b_busyX",  32'(hi_busy),  32'd0);
    chk("b_validX", 32'(hi_valid), 32'd0);
    tick();
    chk("b_done_off", 32'(hi_done), 32'd0);

    // Full set via elite_count=0, then clamping via 7
    elite_count = 3'd0;
    push_exp(D1, P1, 4, 4);
    sortdone = 1'b1;
    tick();
    sortdone = 1'b0;
    wait_idle(n);
    chk("full_len", 32'(n), 32'd4);
    elite_count = 3'd7;
    push_exp(D1, P1, 4, 4);
    sortdone = 1'b1;
    tick();
    sortdone = 1'b0;
    wait_idle(n);
    chk("clamp_len", 32'(n), 32'd4);

    // Backpressure at rank 1
    elite_count = 3'd4;
    push_exp(D1, P1, 4, 4);
    sortdone = 1'b1;
    tick();
    sortdone = 1'b0;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", 32'(hi_valid), 32'd1);
      chk("bp_value", 32'(hi_value), 32'd9);
      chk("bp_index", 32'(hi_index), 32'd3);
      chk("bp_rank",  32'(hi_rank),  32'd1);
      chk("bp_lo_value", 32'(lo_value), 32'd7);
    end
    out_ready = 1'b1;
    wait_idle(n);

    // Overrun: second strobe at rank 0 is dropped
    elite_count = 3'd2;
    out_ready   = 1'b0;
    push_exp(D1, P1, 2, 2);
    sortdone = 1'b1;
    tick();
    sorted = D2; sorted_positions = P2;
    tick();
    sortdone = 1'b0;
    chk("ov_pulse", 32'(hi_overrun), 32'd1);
    chk("ov_value", 32'(hi_value),   32'd20);
    tick();
    chk("ov_clear", 32'(hi_overrun), 32'd0);
    out_ready = 1'b1;
    wait_idle(n);

    // Back-to-back capture on the final handshake
    sorted = D1; sorted_positions = P1; elite_count = 3'd2;
    push_exp(D1, P1, 2, 2);
    push_exp(D2, P2, 3, 3);
    sortdone = 1'b1;
    tick();
    sortdone = 1'b0;
    tick();
    sorted = D2; sorted_positions = P2; elite_count = 3'd3;
    sortdone = 1'b1;
    tick();
    sortdone = 1'b0;
    chk("bb_done",    32'(hi_done),    32'd1);
    chk("bb_valid",   32'(hi_valid),   32'd1);
    chk("bb_rank",    32'(hi_rank),    32'd0);
    chk("bb_value",   32'(hi_value),   32'd50);
    chk("bb_lovalue", 32'(lo_value),   32'd10);
    chk("bb_overrun", 32'(hi_overrun), 32'd0);
    wait_idle(n);
    chk("bb_len", 32'(n), 32'd3);

    // Reset asserted at rank 1
    sorted = D1; sorted_positions = P1; elite_count = 3'd4;
    push_exp(D1, P1, 4, 1);
    sortdone = 1'b1;
    tick();
    sortdone = 1'b0;
    tick();
    out_ready = 1'b0;
    reset     = 1'b1;
    tick();
    chk("mr_valid", 32'(hi_valid), 32'd0);
    chk("mr_value", 32'(hi_value), 32'd0);
    chk("mr_index", 32'(hi_index), 32'd0);
    chk("mr_rank",  32'(hi_rank),  32'd0);
    chk("mr_last",  32'(hi_last),  32'd0);
    chk("mr_busy",  32'(hi_busy),  32'd0);
    chk("mr_done",  32'(hi_done),  32'd0);
    reset = 1'b0;
    tick();
    chk("mr_done2", 32'(hi_done), 32'd0);
    out_ready   = 1'b1;
    elite_count = 3'd2;
    push_exp(D1, P1, 2, 2);
    sortdone = 1'b1;
    tick();
    sortdone = 1'b0;
    wait_idle(n);
    chk("mr_len", 32'(n), 32'd2);

    tick();
    tick();
    chk("q_hi_empty", 32'(q_hi.size()), 32'd0);
    chk("q_lo_empty", 32'(q_lo.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
